// File: rtl/instr_mem_responder.sv
// instr_mem_responder
// Handshaked responder for instruction storage. Translates CPU byte
// addresses to word indices, flags misaligned / out-of-range requests,
// waits a fixed number of cycles, then commits the access and offers a
// response on a valid/ready channel. One request in flight at a time.
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80020000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  // Byte span of the storage, kept 33 bits wide so the range compare
  // cannot overflow even for the largest power-of-two depth.
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  count_reg;
  logic        write_reg;
  logic [31:0] wdata_reg;
  logic [31:0] offset_reg;
  logic        below_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic             commit;
  logic             err_now;
  logic [IDX_W-1:0] idx;

  // The access completes on the WAIT edge where the counter has run out.
  assign commit  = (state_reg == WAIT) && (count_reg == 4'd0);
  // Error is judged on the captured request; below-base is remembered at
  // acceptance because the wrapped offset alone cannot reveal it.
  assign err_now = below_reg
                 || ({1'b0, offset_reg} >= SPAN)
                 || (offset_reg[1:0] != 2'b00);
  assign idx     = offset_reg[IDX_W+1:2];

  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  // State register; reset wins over every transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        if (count_reg == 4'd0) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, latency countdown, and response data/flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= 4'd0;
      write_reg  <= 1'b0;
      wdata_reg  <= 32'd0;
      offset_reg <= 32'd0;
      below_reg  <= 1'b0;
      rdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg  <= req_write;
            wdata_reg  <= req_wdata;
            offset_reg <= req_addr - BASE_ADDR;
            below_reg  <= (req_addr < BASE_ADDR);
            count_reg  <= LAT_LOAD;
          end
        end
        WAIT: begin
          if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
          end else begin
            err_reg <= err_now;
            if (!write_reg && !err_now) begin
              rdata_reg <= mem[idx];
            end else begin
              rdata_reg <= 32'd0;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
          end
        end
        default: begin
          count_reg <= 4'd0;
        end
      endcase
    end
  end

  // Storage write port: only legal writes, only on the commit edge, and
  // never on an edge where reset is asserted.
  always_ff @(posedge clock) begin
    if (!reset && commit && write_reg && !err_now) begin
      mem[idx] <= wdata_reg;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: one instance with LATENCY=1 and
// one with LATENCY=4, sharing the request payload and response-ready lines.
// `sel` routes req_valid to one instance and muxes its outputs back.
module tb_instr_mem_responder;

  logic        clock;
  logic        rst1, rst4;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic        v1, v4;
  logic        rdy1, rdy4, rv1, rv4, re1, re4;
  logic [31:0] rd1, rd4;

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  assign v1 = req_valid & ~sel;
  assign v4 = req_valid & sel;
  assign m_req_ready  = sel ? rdy4 : rdy1;
  assign m_resp_valid = sel ? rv4  : rv1;
  assign m_resp_rdata = sel ? rd4  : rd1;
  assign m_resp_err   = sel ? re4  : re1;

  instr_mem_responder #(.BASE_ADDR(32'h80020000), .DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clock(clock), .reset(rst1),
    .req_valid(v1), .req_ready(rdy1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready),
    .resp_rdata(rd1), .resp_err(re1)
  );

  instr_mem_responder #(.BASE_ADDR(32'h80020000), .DEPTH_WORDS(1024), .LATENCY(4)) dut4 (
    .clock(clock), .reset(rst4),
    .req_valid(v4), .req_ready(rdy4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv4), .resp_ready(resp_ready),
    .resp_rdata(rd4), .resp_err(re4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached got running want finished");
    $fatal(1, "watchdog");
  end

  // One complete request/response on the selected instance. Returns the
  // response payload, the latency in edges from acceptance to resp_valid,
  // and the cycle number of the accepting edge.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int acc);
    int k;
    @(negedge clock);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    k = 0;
    while (m_req_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (m_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", a, m_req_ready);
    end
    @(posedge clock);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (m_resp_valid !== 1'b1 && k < 50);
    checks++;
    if (m_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout addr=%h got resp_valid=%b want 1", a, m_resp_valid);
    end
    lat = k - 1;
    rd  = m_resp_rdata;
    er  = m_resp_err;
    $display("xact dut=%0d w=%0b addr=%h wdata=%h -> rdata=%h err=%b lat=%0d acc=%0d",
             sel ? 4 : 1, w, a, d, rd, er, lat, acc);
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clock);
    rst1 = 1'b0; rst4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 32'd0 || re1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_l1 cyc%0d got rdy=%b v=%b rd=%h err=%b want 1 0 00000000 0",
                 i, rdy1, rv1, rd1, re1);
      end
      checks++;
      if (rdy4 !== 1'b1 || rv4 !== 1'b0 || rd4 !== 32'd0 || re4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_l4 cyc%0d got rdy=%b v=%b rd=%h err=%b want 1 0 00000000 0",
                 i, rdy4, rv4, rd4, re4);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read;
    logic [31:0] addrs [4];
    logic [31:0] datas [4];
    logic        wr    [4];
    logic [31:0] exp_rd [4];
    logic [31:0] rd;
    logic        er;
    int lat, acc, prev;
    sel = 1'b0;
    addrs  = '{32'h80020000, 32'h80020004, 32'h80020000, 32'h80020004};
    datas  = '{32'h20080005, 32'h01094020, 32'h0, 32'h0};
    wr     = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_rd = '{32'h0, 32'h0, 32'h20080005, 32'h01094020};
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      xact(wr[i], addrs[i], datas[i], rd, er, lat, acc);
      checks++;
      if (rd !== exp_rd[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_data #%0d got rdata=%h err=%b want %h 0", i, rd, er, exp_rd[i]);
      end
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL wr_rd_latency #%0d got %0d want 1", i, lat);
      end
      if (i > 0) begin
        checks++;
        if (acc - prev != 3) begin
          errors++;
          $display("FAIL wr_rd_spacing #%0d got %0d want 3", i, acc - prev);
        end
      end
      prev = acc;
    end
    $display("test_write_read done");
  endtask

  task automatic test_errors;
    logic [31:0] ea [4];
    logic        ew [4];
    logic [31:0] rd;
    logic        er;
    int lat, acc;
    sel = 1'b0;
    ea = '{32'h80020002, 32'h8001FFFC, 32'h80021000, 32'h80021000};
    ew = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      xact(ew[i], ea[i], 32'hBADBAD00, rd, er, lat, acc);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL err_req addr=%h got err=%b rdata=%h want 1 00000000", ea[i], er, rd);
      end
    end
    xact(1'b0, 32'h80020000, 32'h0, rd, er, lat, acc);
    checks++;
    if (rd !== 32'h20080005 || er !== 1'b0) begin
      errors++;
      $display("FAIL err_storage_word0 got rdata=%h err=%b want 20080005 0", rd, er);
    end
    $display("test_errors done");
  endtask

  task automatic test_backpressure;
    int k, m, acc;
    sel = 1'b0;
    resp_ready = 1'b0;
    @(negedge clock);
    req_write = 1'b0; req_addr = 32'h80020000; req_wdata = 32'h0; req_valid = 1'b1;
    k = 0;
    while (rdy1 !== 1'b1 && k < 50) begin @(negedge clock); k++; end
    @(posedge clock);
    #1 req_valid = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (rv1 !== 1'b1 && k < 50);
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 32'h20080005 || re1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_resp got v=%b rd=%h err=%b want 1 20080005 0", rv1, rd1, re1);
    end
    // A second request waits while the first response is stalled.
    req_addr = 32'h80020004; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (rv1 !== 1'b1 || rd1 !== 32'h20080005 || re1 !== 1'b0 || rdy1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got v=%b rd=%h err=%b rdy=%b want 1 20080005 0 0",
                 i, rv1, rd1, re1, rdy1);
      end
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 m = cyc;
    @(negedge clock);
    checks++;
    if (rdy1 !== 1'b1 || rv1 !== 1'b0 || rd1 !== 32'd0) begin
      errors++;
      $display("FAIL bp_after_handshake got rdy=%b v=%b rd=%h want 1 0 00000000", rdy1, rv1, rd1);
    end
    @(posedge clock);
    #1 acc = cyc;
    req_valid = 1'b0;
    checks++;
    if (acc != m + 1) begin
      errors++;
      $display("FAIL bp_accept_edge got %0d want %0d", acc, m + 1);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (rv1 !== 1'b1 || rd1 !== 32'h01094020) begin
      errors++;
      $display("FAIL bp_second_resp got v=%b rd=%h want 1 01094020", rv1, rd1);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd;
    logic        er;
    int lat, acc, k;
    sel = 1'b1;
    xact(1'b1, 32'h80020008, 32'h11112222, rd, er, lat, acc);
    checks++;
    if (lat != 4 || er !== 1'b0) begin
      errors++;
      $display("FAIL rmw_prime got lat=%0d err=%b want 4 0", lat, er);
    end
    @(negedge clock);
    req_write = 1'b1; req_addr = 32'h80020008; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    k = 0;
    while (rdy4 !== 1'b1 && k < 50) begin @(negedge clock); k++; end
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rdy4 !== 1'b0) begin
      errors++;
      $display("FAIL rmw_accepted got rdy=%b want 0", rdy4);
    end
    @(negedge clock);
    rst4 = 1'b1;
    @(negedge clock);
    checks++;
    if (rdy4 !== 1'b1 || rv4 !== 1'b0 || rd4 !== 32'd0 || re4 !== 1'b0) begin
      errors++;
      $display("FAIL rmw_reset_outputs got rdy=%b v=%b rd=%h err=%b want 1 0 00000000 0",
               rdy4, rv4, rd4, re4);
    end
    rst4 = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (rv4 !== 1'b0 || rdy4 !== 1'b1) begin
        errors++;
        $display("FAIL rmw_no_stale_resp got v=%b rdy=%b want 0 1", rv4, rdy4);
      end
    end
    xact(1'b0, 32'h80020008, 32'h0, rd, er, lat, acc);
    checks++;
    if (rd !== 32'h11112222 || er !== 1'b0) begin
      errors++;
      $display("FAIL rmw_storage got rdata=%h err=%b want 11112222 0", rd, er);
    end
    $display("test_reset_mid_write done");
  endtask

  task automatic test_last_word;
    logic [31:0] rd;
    logic        er;
    int lat, acc, prev;
    sel = 1'b1;
    xact(1'b1, 32'h80020FFC, 32'hCAFEF00D, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'd0 || lat != 4) begin
      errors++;
      $display("FAIL last_write got err=%b rdata=%h lat=%0d want 0 00000000 4", er, rd, lat);
    end
    prev = acc;
    xact(1'b0, 32'h80020FFC, 32'h0, rd, er, lat, acc);
    checks++;
    if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL last_read got err=%b rdata=%h want 0 cafef00d", er, rd);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL last_latency got %0d want 4", lat);
    end
    checks++;
    if (acc - prev != 6) begin
      errors++;
      $display("FAIL last_spacing got %0d want 6", acc - prev);
    end
    $display("test_last_word done");
  endtask

  initial begin
    sel = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b1;
    rst1 = 1'b1; rst4 = 1'b1;
    test_reset();
    test_write_read();
    test_errors();
    test_backpressure();
    test_reset_mid_write();
    test_last_word();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
